// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE Z-buffer controller.
package redmule_pkg;

  typedef enum logic [1:0] {
    ZB_IDLE  = 2'd0,
    ZB_CLEAR = 2'd1,
    ZB_FILL  = 2'd2,
    ZB_DRAIN = 2'd3
  } z_buf_ctrl_state_e;

endpackage

// File: rtl/redmule_z_buffer_ctrl.sv
// Z-buffer controller: clears the buffer, accepts engine row writes, then drains rows or columns.
// Column drain exists only when REDMULE_ZBUF_TRANSPOSE_EN is defined; otherwise transpose_i is ignored.
module redmule_z_buffer_ctrl
  import redmule_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [$clog2(ROWS):0]   num_rows_i,
  input  logic                    transpose_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_sel_col_o,
  output logic                    clear_o,
  output logic                    row_write_en_o,
  output logic [$clog2(ROWS)-1:0] row_write_addr_o,
  output logic                    row_read_en_o,
  output logic [$clog2(ROWS)-1:0] row_read_addr_o,
  output logic                    col_read_en_o,
  output logic [$clog2(COLS)-1:0] col_read_addr_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned NRW  = $clog2(ROWS) + 1;
  localparam int unsigned RAW  = $clog2(ROWS);
  localparam int unsigned CAW  = $clog2(COLS);
  localparam int unsigned MAXB = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  z_buf_ctrl_state_e r_state;
  logic [NRW-1:0]    r_num_rows;
  logic              r_transpose;
  logic [NRW-1:0]    r_wr_cnt;
  logic [CW-1:0]     r_rd_cnt;
  logic              r_rd_done;
  logic              r_out_valid;
  logic              r_done;

  logic              w_tr_in;
  logic [NRW-1:0]    w_num_rows_sat;
  logic [CW-1:0]     w_beats;
  logic              w_wr_hs;
  logic              w_wr_last;
  logic              w_rd_issue;
  logic              w_rd_last;
  logic              w_out_hs;

  // Decode handshakes, tile length and read-issue conditions
  always_comb begin
`ifdef REDMULE_ZBUF_TRANSPOSE_EN
    w_tr_in = transpose_i;
`else
    w_tr_in = transpose_i & 1'b0;
`endif
    if ((num_rows_i == NRW'(0)) || (num_rows_i > NRW'(ROWS))) begin
      w_num_rows_sat = NRW'(ROWS);
    end else begin
      w_num_rows_sat = num_rows_i;
    end
    if (r_transpose) begin
      w_beats = CW'(COLS);
    end else begin
      w_beats = CW'(r_num_rows);
    end
    w_wr_hs    = (r_state == ZB_FILL) && in_valid_i;
    w_wr_last  = w_wr_hs && (r_wr_cnt == (r_num_rows - NRW'(1)));
    // One read may be in flight: issue only if the output slot is free or being emptied
    w_rd_issue = (r_state == ZB_DRAIN) && !r_rd_done && (!r_out_valid || out_ready_i);
    w_rd_last  = (r_rd_cnt == (w_beats - CW'(1)));
    w_out_hs   = r_out_valid && out_ready_i;
  end

  // Tile sequencing FSM with latched configuration, output-valid and done pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ZB_IDLE;
      r_num_rows  <= NRW'(0);
      r_transpose <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ZB_IDLE: begin
          r_out_valid <= 1'b0;
          if (start_i && !r_done) begin
            r_state     <= ZB_CLEAR;
            r_num_rows  <= w_num_rows_sat;
            r_transpose <= w_tr_in;
          end
        end
        ZB_CLEAR: begin
          r_out_valid <= 1'b0;
          r_state     <= ZB_FILL;
        end
        ZB_FILL: begin
          r_out_valid <= 1'b0;
          if (w_wr_last) begin
            r_state <= ZB_DRAIN;
          end
        end
        ZB_DRAIN: begin
          if (w_rd_issue) begin
            r_out_valid <= 1'b1;
          end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
          end
          if (w_out_hs && r_rd_done) begin
            r_state <= ZB_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ZB_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Row write counter, restarted by every CLEAR
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_cnt <= NRW'(0);
    end else if (r_state == ZB_CLEAR) begin
      r_wr_cnt <= NRW'(0);
    end else if (w_wr_hs) begin
      r_wr_cnt <= r_wr_cnt + NRW'(1);
    end
  end

  // Read counter saturates at the last beat; r_rd_done marks all reads issued
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_cnt  <= CW'(0);
      r_rd_done <= 1'b0;
    end else if (r_state == ZB_CLEAR) begin
      r_rd_cnt  <= CW'(0);
      r_rd_done <= 1'b0;
    end else if (w_rd_issue) begin
      if (w_rd_last) begin
        r_rd_done <= 1'b1;
      end else begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
    end
  end

  assign busy_o           = (r_state != ZB_IDLE);
  assign done_o           = r_done;
  assign clear_o          = (r_state == ZB_CLEAR);
  assign in_ready_o       = (r_state == ZB_FILL);
  assign row_write_en_o   = w_wr_hs;
  assign row_write_addr_o = r_wr_cnt[RAW-1:0];
  assign out_valid_o      = r_out_valid;
  assign row_read_en_o    = w_rd_issue && !r_transpose;
  assign row_read_addr_o  = r_rd_cnt[RAW-1:0];

`ifdef REDMULE_ZBUF_TRANSPOSE_EN
  assign col_read_en_o    = w_rd_issue && r_transpose;
  assign col_read_addr_o  = r_rd_cnt[CAW-1:0];
  assign out_sel_col_o    = (r_state == ZB_DRAIN) && r_transpose;
`else
  assign col_read_en_o    = 1'b0;
  assign col_read_addr_o  = CAW'(0);
  assign out_sel_col_o    = 1'b0;
`endif

endmodule

// File: tb/tb_redmule_z_buffer_ctrl.sv
// Directed self-checking bench for redmule_z_buffer_ctrl (ROWS=4, COLS=4).
module tb_redmule_z_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] num_rows_i = 3'd0;
  logic       transpose_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       in_ready_o, out_valid_o, out_sel_col_o, clear_o;
  logic       row_write_en_o, row_read_en_o, col_read_en_o, busy_o, done_o;
  logic [1:0] row_write_addr_o, row_read_addr_o, col_read_addr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int m_clear, m_wr, m_rd, m_col, m_beats, m_done, m_err;
  logic m_timeout;

  redmule_z_buffer_ctrl #(.ROWS(4), .COLS(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .num_rows_i(num_rows_i),
    .transpose_i(transpose_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_sel_col_o(out_sel_col_o),
    .clear_o(clear_o), .row_write_en_o(row_write_en_o), .row_write_addr_o(row_write_addr_o),
    .row_read_en_o(row_read_en_o), .row_read_addr_o(row_read_addr_o),
    .col_read_en_o(col_read_en_o), .col_read_addr_o(col_read_addr_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Runs one tile from IDLE and records what the DUT did; protocol slips are tallied in m_err.
  task automatic run_tile(input int nrows, input logic tr, input logic exp_sel,
                          input logic [3:0] rdy_pat, input logic [3:0] vld_pat,
                          input logic spam, input int abort_beat);
    int cyc, exp_wr, exp_rd, exp_col, last_hs;
    logic prev_stall, seen_busy, fin;
    logic [1:0] prev_ra, prev_ca;
    m_clear = 0; m_wr = 0; m_rd = 0; m_col = 0; m_beats = 0; m_done = 0; m_err = 0;
    m_timeout = 1'b0;
    cyc = 0; exp_wr = 0; exp_rd = 0; exp_col = 0; last_hs = -10;
    prev_stall = 1'b0; seen_busy = 1'b0; fin = 1'b0; prev_ra = 2'd0; prev_ca = 2'd0;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      start_i     = (cyc == 0) || spam;
      num_rows_i  = 3'(nrows);
      transpose_i = tr;
      in_valid_i  = vld_pat[cyc % 4];
      out_ready_i = rdy_pat[cyc % 4];
      #1;
      if (clear_o) m_clear++;
      if (row_write_en_o) begin
        if (int'(row_write_addr_o) != exp_wr) m_err++;
        if (!in_valid_i || !in_ready_o) m_err++;
        exp_wr++; m_wr++;
      end
      if (in_ready_o && !busy_o) m_err++;
      if (row_read_en_o) begin
        if (int'(row_read_addr_o) != exp_rd) m_err++;
        exp_rd++; m_rd++;
      end
      if (col_read_en_o) begin
        if (int'(col_read_addr_o) != exp_col) m_err++;
        exp_col++; m_col++;
      end
      if (prev_stall && !out_valid_o) m_err++;
      if (out_valid_o && !out_ready_i) begin
        if (row_read_en_o || col_read_en_o) m_err++;
        if (prev_stall && (row_read_addr_o != prev_ra || col_read_addr_o != prev_ca)) m_err++;
      end
      if ((row_read_en_o || col_read_en_o || out_valid_o) && out_sel_col_o != exp_sel) m_err++;
      if ((!busy_o || clear_o || in_ready_o) && out_sel_col_o) m_err++;
      if (out_valid_o && out_ready_i) begin
        m_beats++; last_hs = cyc;
      end
      if (busy_o) seen_busy = 1'b1;
      if (seen_busy && !busy_o && !done_o) m_err++;
      if (done_o) begin
        m_done++; fin = 1'b1;
        if (busy_o || cyc != last_hs + 1) m_err++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_ra = row_read_addr_o; prev_ca = col_read_addr_o;
      if (abort_beat >= 0 && m_beats == abort_beat && out_valid_o && !fin) begin
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        fin = 1'b1;
      end
      cyc++;
    end
    if (!fin) m_timeout = 1'b1;
    start_i = 1'b0; in_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] v;
    rst_ni = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1; transpose_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    v = {busy_o, out_valid_o, clear_o, done_o, in_ready_o, row_write_en_o, row_write_addr_o,
         row_read_en_o, row_read_addr_o, col_read_en_o, col_read_addr_o, out_sel_col_o};
    n_checks++;
    if (v !== 15'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", v); end
    rst_ni = 1'b1; in_valid_i = 1'b0; transpose_i = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({busy_o, out_valid_o, clear_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 000", {busy_o, out_valid_o, clear_o});
    end
  endtask

  task automatic check_tile(input string name, input logic [47:0] exp);
    logic [47:0] obs;
    obs = {8'(m_clear), 8'(m_wr), 8'(m_rd), 8'(m_col), 8'(m_beats), 8'(m_done)};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s_counts: got %h expected %h", name, obs, exp); end
    n_checks++;
    if (m_err != 0 || m_timeout) begin
      n_fail++; $display("FAIL %s_protocol: got %0d errors timeout=%0b expected 0", name, m_err, m_timeout);
    end
  endtask

  task automatic test_basic;
    run_tile(4, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, -1);
    check_tile("basic", {8'd1, 8'd4, 8'd4, 8'd0, 8'd4, 8'd1});
  endtask

  task automatic test_back_to_back;
    run_tile(1, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, -1);
    check_tile("single_row", {8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1});
    run_tile(7, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, -1);
    check_tile("oversat", {8'd1, 8'd4, 8'd4, 8'd0, 8'd4, 8'd1});
  endtask

  task automatic test_stall;
    run_tile(4, 1'b0, 1'b0, 4'b1001, 4'b1111, 1'b0, -1);
    check_tile("stall", {8'd1, 8'd4, 8'd4, 8'd0, 8'd4, 8'd1});
  endtask

  task automatic test_fill_gaps;
    run_tile(3, 1'b0, 1'b0, 4'b1111, 4'b0101, 1'b0, -1);
    check_tile("fill_gaps", {8'd1, 8'd3, 8'd3, 8'd0, 8'd3, 8'd1});
  endtask

  task automatic test_transpose;
`ifdef REDMULE_ZBUF_TRANSPOSE_EN
    run_tile(2, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, -1);
    check_tile("transpose", {8'd1, 8'd2, 8'd0, 8'd4, 8'd4, 8'd1});
`else
    run_tile(2, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, -1);
    check_tile("transpose_off", {8'd1, 8'd2, 8'd2, 8'd0, 8'd2, 8'd1});
`endif
  endtask

  task automatic test_start_busy;
    run_tile(0, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, -1);
    check_tile("zero_rows_busy_start", {8'd1, 8'd4, 8'd4, 8'd0, 8'd4, 8'd1});
    @(negedge clk);
    start_i = 1'b1; num_rows_i = 3'd4;
    #1;
    n_checks++;
    if ({busy_o, clear_o} !== 2'b00) begin
      n_fail++; $display("FAIL start_with_done: got %b expected 00", {busy_o, clear_o});
    end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, clear_o} !== 2'b11) begin
      n_fail++; $display("FAIL restart_after_done: got %b expected 11", {busy_o, clear_o});
    end
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_abort;
    int late_done;
    run_tile(4, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 2);
    late_done = m_done;
    #1;
    n_checks++;
    if ({busy_o, out_valid_o} !== 2'b00 || m_beats != 2) begin
      n_fail++; $display("FAIL abort_state: got busy/valid %b beats %0d expected 00 and 2",
                         {busy_o, out_valid_o}, m_beats);
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (done_o) late_done++;
    end
    n_checks++;
    if (late_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", late_done); end
    run_tile(4, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, -1);
    check_tile("after_abort", {8'd1, 8'd4, 8'd4, 8'd0, 8'd4, 8'd1});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_fill_gaps();
    test_transpose();
    test_start_busy();
    test_abort();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/redmule_z_buffer_ctrl.md
REDMULE_Z_BUFFER_CTRL -- requirements
Module: redmule_z_buffer_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, the Z-buffer row count (at least 2).
REQ-002 SHALL have parameter COLS, default 4, the Z-buffer column count (at least 2).
REQ-003 SHALL have ports clk_i input 1 (clock) and rst_ni input 1 (reset); reset is synchronous and active-low, sampled on posedge clk_i.
REQ-004 SHALL have start_i input 1, a one-cycle tile start pulse, accepted only in IDLE.
REQ-005 SHALL have num_rows_i input $clog2(ROWS)+1, the valid rows in the tile (1..ROWS), latched at start.
REQ-006 SHALL have transpose_i input 1, selecting column drain (1) or row drain (0), latched at start.
REQ-007 SHALL have in_valid_i input 1 and in_ready_o output 1, the engine row-write handshake.
REQ-008 SHALL have out_valid_o output 1 and out_ready_i input 1, the streamer drain handshake.
REQ-009 SHALL have out_sel_col_o output 1, meaning the current drain beat is column data.
REQ-010 SHALL have clear_o output 1, row_write_en_o output 1 and row_write_addr_o output $clog2(ROWS), the buffer write controls.
REQ-011 SHALL have row_read_en_o output 1, row_read_addr_o output $clog2(ROWS), col_read_en_o output 1 and col_read_addr_o output $clog2(COLS), the buffer read controls.
REQ-012 SHALL have busy_o output 1 (state != IDLE) and done_o output 1 (one-cycle pulse).

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, FILL and DRAIN.
REQ-014 IDLE with start_i=1 SHALL go to CLEAR; start_i outside IDLE SHALL be ignored.
REQ-015 CLEAR SHALL assert clear_o for exactly 1 cycle, then go to FILL.
REQ-016 num_rows_i=0 or num_rows_i>ROWS SHALL be saturated to ROWS at latch time.
REQ-017 FILL SHALL keep in_ready_o=1.
REQ-018 Each FILL handshake SHALL drive row_write_en_o=1 in the same cycle, with row_write_addr_o = write counter (starting at 0).
REQ-019 On the handshake of beat num_rows-1, FILL SHALL go to DRAIN.
REQ-020 In every state except FILL, in_ready_o and row_write_en_o SHALL be 0.
REQ-021 DRAIN beat count SHALL be num_rows for row mode and COLS for column mode.
REQ-022 A DRAIN read SHALL issue when reads remain AND (out_valid_o=0 OR out_ready_i=1).
REQ-023 An issued read SHALL pulse row_read_en_o (row mode) or col_read_en_o (column mode) with the read counter on the matching address port.
REQ-024 out_valid_o SHALL rise the cycle after a read issues, matching the buffer's 1-cycle registered read address.
REQ-025 out_valid_o SHALL hold while out_ready_i=0, with read enables low and the addresses stable.
REQ-026 Back-to-back handshakes SHALL sustain 1 beat/cycle.
REQ-027 On the handshake of the last beat with no read pending, DRAIN SHALL pulse done_o and go to IDLE.
REQ-028 The write counter SHALL wrap only via reset or the next CLEAR; the read counter SHALL never exceed the beat count - 1.
REQ-029 out_sel_col_o SHALL equal the latched transpose bit while in DRAIN, and 0 otherwise.
REQ-030 start_i together with done_o in the same cycle SHALL be ignored; start is re-accepted from IDLE the next cycle.

Reset
REQ-031 With rst_ni=0 at a clock edge, the FSM SHALL go to IDLE and the counters and latched configuration SHALL go to 0.
REQ-032 After reset, all outputs SHALL be 0, including busy_o, out_valid_o, clear_o and the read/write enables and addresses.
REQ-033 Reset mid-FILL or mid-DRAIN SHALL abort the tile with no done_o; the next start SHALL re-clear the buffer.

Configuration
REQ-034 Macro REDMULE_ZBUF_TRANSPOSE_EN SHALL gate column drain.
REQ-035 With REDMULE_ZBUF_TRANSPOSE_EN defined, transpose_i SHALL be honoured as in REQ-021 to REQ-029.
REQ-036 Without REDMULE_ZBUF_TRANSPOSE_EN, transpose_i SHALL be ignored (row drain always), and col_read_en_o, col_read_addr_o and out_sel_col_o SHALL be tied 0.

Structure
REQ-037 The FSM state enum SHALL live in redmule_pkg as z_buf_ctrl_state_e.
REQ-038 The controller SHALL be flat, with no sub-modules; counters SHALL be inline always_ff blocks.

Verification
REQ-039 ROWS=4, num_rows=4, transpose=0, out_ready=1: clear_o for 1 cycle; 4 writes at addresses 0..3; 4 row reads at 0..3; done_o 1 cycle after the last out handshake.
REQ-040 num_rows=2, transpose=1 (macro on), COLS=4: 2 writes, then col_read_addr_o 0..3, out_sel_col_o=1, and exactly 4 out beats.
REQ-041 out_ready_i toggling 1,0,0,1 in DRAIN: out_valid_o held; read address and enables stable during stalls; no beat lost or duplicated.
REQ-042 in_valid_i gaps during FILL: row_write_en_o follows the handshakes only; addresses stay contiguous 0..num_rows-1.
REQ-043 rst_ni=0 during DRAIN beat 2, then start: full clear_o, no done_o for the aborted tile, and the new tile completes correctly.
REQ-044 num_rows_i=0 and start during busy: 0 saturates to ROWS beats; start while busy is ignored (busy_o unchanged, no extra clear_o).
